// File: rtl/port_reset_fsm_mc.sv
// Multi-port AFU reset sequencer: one HOLD -> DEACT -> CLEAR -> SET machine per port.
// Defining PORT_RESET_DRAIN_TIMEOUT_EN adds a bounded wait for the MMIO response slot in SET.

module port_reset_fsm_mc #(
    parameter int unsigned NUM_PORTS            = 4,
    parameter int unsigned SYNC_RESET_MIN_WIDTH = 256,
    parameter int unsigned DRAIN_TIMEOUT        = 4096
) (
    input  logic                 clk_2x,
    input  logic                 rst_n_2x,
    input  logic [NUM_PORTS-1:0] i_port_reset,
    input  logic [NUM_PORTS-1:0] i_flr_rcvd,
    input  logic [NUM_PORTS-1:0] i_sel_mmio_rsp,
    input  logic [NUM_PORTS-1:0] i_read_flush_done,
    output logic [NUM_PORTS-1:0] o_afu_softreset,
    output logic [NUM_PORTS-1:0] o_port_softreset_n,
    output logic [NUM_PORTS-1:0] o_flr_completed,
    output logic [NUM_PORTS-1:0] o_flr_pending,
    output logic [NUM_PORTS-1:0] o_reset_flush_done,
    output logic [NUM_PORTS-1:0] o_port_busy,
    output logic [NUM_PORTS-1:0] o_drain_timeout_err
);

    localparam int unsigned       TimerW   = $clog2(SYNC_RESET_MIN_WIDTH) + 1;
    localparam logic [TimerW-1:0] TimerMax = TimerW'(SYNC_RESET_MIN_WIDTH);

`ifdef PORT_RESET_DRAIN_TIMEOUT_EN
    localparam int unsigned       DrainW    = $clog2(DRAIN_TIMEOUT) + 1;
    localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_TIMEOUT - 1);
`else
    // Keeps the parameter referenced when the timeout logic is compiled out.
    logic unused_drain_cfg;
    assign unused_drain_cfg    = (DRAIN_TIMEOUT == 0);
    assign o_drain_timeout_err = '0;
`endif

    typedef enum logic [3:0] {
        StHold  = 4'b0001,
        StDeact = 4'b0010,
        StClear = 4'b0100,
        StSet   = 4'b1000
    } state_e;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        state_e            state_q;
        logic [TimerW-1:0] timer_q;
        logic              flr_flag_q;
        logic              flr_done_q;
        logic              afu_s1_q;
        logic              port_n_s1_q;
        logic              busy_s1_q;
        logic              deact_s1_q;
        logic              afu_q;
        logic              port_n_q;
        logic              busy_q;
        logic              flush_done_q;
        logic              src;
`ifdef PORT_RESET_DRAIN_TIMEOUT_EN
        logic [DrainW-1:0] drain_cnt_q;
        logic              timeout_q;
`endif

        assign src = i_port_reset[p] | flr_flag_q;

        always_ff @(posedge clk_2x or negedge rst_n_2x) begin
            if (!rst_n_2x) begin
                state_q      <= StHold;
                timer_q      <= '0;
                flr_flag_q   <= 1'b0;
                flr_done_q   <= 1'b0;
                afu_s1_q     <= 1'b1;
                port_n_s1_q  <= 1'b0;
                busy_s1_q    <= 1'b1;
                deact_s1_q   <= 1'b0;
                afu_q        <= 1'b1;
                port_n_q     <= 1'b0;
                busy_q       <= 1'b1;
                flush_done_q <= 1'b0;
`ifdef PORT_RESET_DRAIN_TIMEOUT_EN
                drain_cnt_q  <= '0;
                timeout_q    <= 1'b0;
`endif
            end else begin
                flr_done_q <= 1'b0;
                flr_flag_q <= flr_flag_q | i_flr_rcvd[p];
`ifdef PORT_RESET_DRAIN_TIMEOUT_EN
                timeout_q  <= 1'b0;
`endif

                // Two register stages between state and pins: decode, then output.
                afu_s1_q     <= (state_q != StClear);
                port_n_s1_q  <= (state_q == StClear) || (state_q == StSet);
                busy_s1_q    <= (state_q != StClear);
                deact_s1_q   <= (state_q == StDeact);
                afu_q        <= afu_s1_q;
                port_n_q     <= port_n_s1_q;
                busy_q       <= busy_s1_q;
                flush_done_q <= i_read_flush_done[p] & deact_s1_q;

                unique case (state_q)
                    StHold: begin
                        if (timer_q == TimerMax) begin
                            state_q <= StDeact;
                        end else begin
                            timer_q <= timer_q + TimerW'(1);
                        end
                    end
                    StDeact: begin
                        // A new FLR on the completion edge keeps the flag set.
                        if (flr_flag_q) begin
                            flr_done_q <= 1'b1;
                            flr_flag_q <= i_flr_rcvd[p];
                        end
                        if (!src) begin
                            state_q <= StClear;
                        end
                    end
                    StClear: begin
`ifdef PORT_RESET_DRAIN_TIMEOUT_EN
                        drain_cnt_q <= '0;
`endif
                        if (src) begin
                            state_q <= StSet;
                        end
                    end
                    StSet: begin
                        timer_q <= '0;
                        if (i_sel_mmio_rsp[p]) begin
                            state_q <= StHold;
                        end
`ifdef PORT_RESET_DRAIN_TIMEOUT_EN
                        else if (drain_cnt_q == DrainLast) begin
                            state_q   <= StHold;
                            timeout_q <= 1'b1;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + DrainW'(1);
                        end
`endif
                    end
                    default: begin
                        state_q <= StHold;
                        timer_q <= '0;
                    end
                endcase
            end
        end

        assign o_afu_softreset[p]    = afu_q;
        assign o_port_softreset_n[p] = port_n_q;
        assign o_flr_completed[p]    = flr_done_q;
        assign o_flr_pending[p]      = flr_flag_q;
        assign o_reset_flush_done[p] = flush_done_q;
        assign o_port_busy[p]        = busy_q;
`ifdef PORT_RESET_DRAIN_TIMEOUT_EN
        assign o_drain_timeout_err[p] = timeout_q;
`endif
    end

endmodule

// File: tb/tb_port_reset_fsm_mc.sv
// Self-checking bench for port_reset_fsm_mc: directed scenarios plus a randomized run
// against a phase/countdown reference model.

module tb_port_reset_fsm_mc;

    localparam int NP = 4;
    localparam int W  = 256;
    localparam int DT = 16;

    localparam int PH_HOLD  = 0;
    localparam int PH_DEACT = 1;
    localparam int PH_CLEAR = 2;
    localparam int PH_SET   = 3;

`ifdef PORT_RESET_DRAIN_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk_2x   = 1'b0;
    logic rst_n_2x = 1'b1;
    logic [NP-1:0] port_reset      = '0;
    logic [NP-1:0] flr_rcvd        = '0;
    logic [NP-1:0] sel_mmio_rsp    = '0;
    logic [NP-1:0] read_flush_done = '0;
    logic [NP-1:0] afu, port_n, flr_comp, flr_pend, flush_done, busy, to_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: current phase, phase one edge earlier, HOLD countdown, SET age.
    int m_phase[NP];
    int m_prev[NP];
    int m_hold[NP];
    int m_age[NP];
    logic [NP-1:0] m_pend, e_afu, e_port_n, e_comp, e_flush, e_busy, e_err;

    always #5 clk_2x = ~clk_2x;

    port_reset_fsm_mc #(
        .NUM_PORTS           (NP),
        .SYNC_RESET_MIN_WIDTH(W),
        .DRAIN_TIMEOUT       (DT)
    ) dut (
        .clk_2x             (clk_2x),
        .rst_n_2x           (rst_n_2x),
        .i_port_reset       (port_reset),
        .i_flr_rcvd         (flr_rcvd),
        .i_sel_mmio_rsp     (sel_mmio_rsp),
        .i_read_flush_done  (read_flush_done),
        .o_afu_softreset    (afu),
        .o_port_softreset_n (port_n),
        .o_flr_completed    (flr_comp),
        .o_flr_pending      (flr_pend),
        .o_reset_flush_done (flush_done),
        .o_port_busy        (busy),
        .o_drain_timeout_err(to_err)
    );

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_phase[p] = PH_HOLD;
            m_prev[p]  = PH_HOLD;
            m_hold[p]  = W + 1;
            m_age[p]   = 0;
        end
        m_pend = '0; e_afu = '1; e_port_n = '0; e_comp = '0;
        e_flush = '0; e_busy = '1; e_err = '0;
    endtask

    task automatic model_step();
        for (int p = 0; p < NP; p++) begin
            int   nxt      = m_phase[p];
            logic pend_old = m_pend[p];
            logic src      = port_reset[p] | pend_old;
            // Pins show the phase held two edges back.
            e_afu[p]    = (m_prev[p] != PH_CLEAR);
            e_busy[p]   = (m_prev[p] != PH_CLEAR);
            e_port_n[p] = (m_prev[p] == PH_CLEAR) || (m_prev[p] == PH_SET);
            e_flush[p]  = read_flush_done[p] & (m_prev[p] == PH_DEACT);
            e_comp[p]   = 1'b0;
            e_err[p]    = 1'b0;
            m_pend[p]   = pend_old | flr_rcvd[p];
            case (m_phase[p])
                PH_HOLD: begin
                    m_hold[p]--;
                    if (m_hold[p] == 0) nxt = PH_DEACT;
                end
                PH_DEACT: begin
                    if (pend_old) begin
                        e_comp[p] = 1'b1;
                        m_pend[p] = flr_rcvd[p];
                    end
                    if (!src) nxt = PH_CLEAR;
                end
                PH_CLEAR: begin
                    if (src) begin
                        nxt      = PH_SET;
                        m_age[p] = 0;
                    end
                end
                default: begin
                    if (sel_mmio_rsp[p]) begin
                        nxt       = PH_HOLD;
                        m_hold[p] = W + 1;
                    end else if (TO_EN && m_age[p] == DT - 1) begin
                        nxt       = PH_HOLD;
                        m_hold[p] = W + 1;
                        e_err[p]  = 1'b1;
                    end else begin
                        m_age[p]++;
                    end
                end
            endcase
            m_prev[p]  = m_phase[p];
            m_phase[p] = nxt;
        end
    endtask

    task automatic tick();
        @(posedge clk_2x);
        model_step();
        @(negedge clk_2x);
    endtask

    task automatic clear_inputs();
        port_reset = '0; flr_rcvd = '0; sel_mmio_rsp = '0; read_flush_done = '0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            tick();
            done = 1'b1;
            for (int p = 0; p < NP; p++)
                if (m_phase[p] != PH_CLEAR || m_prev[p] != PH_CLEAR || m_pend[p]) done = 1'b0;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_wait: model still busy after 3000 cycles");
        end else begin
            tick();
            tick();
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        model_reset();
        #1 rst_n_2x = 1'b0;
        #2;
        n_cmp++; if (afu !== '1) begin n_bad++; $display("FAIL rst_afu: got %b want 1111", afu); end
        n_cmp++; if (port_n !== '0) begin n_bad++; $display("FAIL rst_port_n: got %b want 0000", port_n); end
        n_cmp++; if (flr_comp !== '0) begin n_bad++; $display("FAIL rst_comp: got %b want 0000", flr_comp); end
        n_cmp++; if (flr_pend !== '0) begin n_bad++; $display("FAIL rst_pend: got %b want 0000", flr_pend); end
        n_cmp++; if (flush_done !== '0) begin n_bad++; $display("FAIL rst_flush: got %b want 0000", flush_done); end
        n_cmp++; if (busy !== '1) begin n_bad++; $display("FAIL rst_busy: got %b want 1111", busy); end
        n_cmp++; if (to_err !== '0) begin n_bad++; $display("FAIL rst_err: got %b want 0000", to_err); end
        @(negedge clk_2x);
        @(negedge clk_2x);
        rst_n_2x = 1'b1;
        for (int k = 1; k <= W + 8; k++) begin
            logic [NP-1:0] exp_afu;
            tick();
            exp_afu = (k <= W + 3) ? '1 : '0;
            n_cmp++;
            if (afu !== exp_afu) begin
                n_bad++; $display("FAIL pwr_afu cyc %0d: got %b want %b", k, afu, exp_afu);
            end
            n_cmp++;
            if (port_n !== ~exp_afu) begin
                n_bad++; $display("FAIL pwr_port_n cyc %0d: got %b want %b", k, port_n, ~exp_afu);
            end
            n_cmp++;
            if (busy !== exp_afu) begin
                n_bad++; $display("FAIL pwr_busy cyc %0d: got %b want %b", k, busy, exp_afu);
            end
        end
    endtask

    task automatic test_port_reset();
        int low_cnt = 0;
        logic [NP-1:0] others = ~(NP'(1) << 1);
        for (int j = 1; j <= W + 20; j++) begin
            port_reset[1]   = (j <= 10);
            sel_mmio_rsp[1] = (j >= 6);
            tick();
            n_cmp++;
            if (afu[1] !== e_afu[1]) begin
                n_bad++; $display("FAIL p1_afu cyc %0d: got %b want %b", j, afu[1], e_afu[1]);
            end
            n_cmp++;
            if (port_n[1] !== e_port_n[1]) begin
                n_bad++; $display("FAIL p1_port_n cyc %0d: got %b want %b", j, port_n[1], e_port_n[1]);
            end
            n_cmp++;
            if ((afu & others) !== '0 || (port_n & others) !== others) begin
                n_bad++; $display("FAIL p1_others cyc %0d: got afu %b port_n %b", j, afu, port_n);
            end
            if (j == 2) begin
                n_cmp++;
                if (afu[1] !== 1'b0) begin n_bad++; $display("FAIL p1_afu_early: got %b want 0", afu[1]); end
            end
            if (j == 3) begin
                n_cmp++;
                if (afu[1] !== 1'b1) begin n_bad++; $display("FAIL p1_afu_lat2: got %b want 1", afu[1]); end
            end
            if (port_n[1] === 1'b0) low_cnt++;
        end
        clear_inputs();
        n_cmp++;
        if (low_cnt < W + 1) begin n_bad++; $display("FAIL p1_hold_width: got %0d want >=%0d", low_cnt, W + 1); end
        n_cmp++;
        if (busy[1] !== 1'b0) begin n_bad++; $display("FAIL p1_idle: got busy %b want 0", busy[1]); end
        wait_idle();
    endtask

    task automatic test_flr();
        int pulses = 0;
        sel_mmio_rsp[2] = 1'b1;
        for (int j = 1; j <= W + 20; j++) begin
            flr_rcvd[2] = (j == 1);
            tick();
            n_cmp++;
            if (flr_comp[2] !== e_comp[2]) begin
                n_bad++; $display("FAIL flr_comp cyc %0d: got %b want %b", j, flr_comp[2], e_comp[2]);
            end
            n_cmp++;
            if (flr_pend[2] !== m_pend[2]) begin
                n_bad++; $display("FAIL flr_pend cyc %0d: got %b want %b", j, flr_pend[2], m_pend[2]);
            end
            if (j == 1) begin
                n_cmp++;
                if (flr_pend[2] !== 1'b1) begin n_bad++; $display("FAIL flr_set: got %b want 1", flr_pend[2]); end
            end
            if (flr_comp[2] === 1'b1) pulses++;
        end
        clear_inputs();
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL flr_pulses: got %0d want 1", pulses); end
        n_cmp++; if (flr_pend[2] !== 1'b0) begin n_bad++; $display("FAIL flr_pend_end: got %b want 0", flr_pend[2]); end
        n_cmp++; if (busy[2] !== 1'b0) begin n_bad++; $display("FAIL flr_clear: got busy %b want 0", busy[2]); end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int first = -1;
        int second = -1;
        bit sent = 1'b0;
        sel_mmio_rsp[2] = 1'b1;
        for (int j = 1; j <= W + 20; j++) begin
            bit req = !sent && j > 1 && m_phase[2] == PH_DEACT && m_pend[2];
            if (req) sent = 1'b1;
            flr_rcvd[2] = (j == 1) || req;
            tick();
            n_cmp++;
            if (flr_comp[2] !== e_comp[2]) begin
                n_bad++; $display("FAIL b2b_comp cyc %0d: got %b want %b", j, flr_comp[2], e_comp[2]);
            end
            if (flr_comp[2] === 1'b1) begin
                pulses++;
                if (first < 0) first = j; else second = j;
            end
        end
        n_cmp++; if (pulses != 2) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
        n_cmp++;
        if (second != first + 1) begin
            n_bad++; $display("FAIL b2b_adjacent: got cycles %0d,%0d want consecutive", first, second);
        end
        clear_inputs();
        wait_idle();
        pulses = 0;
        sel_mmio_rsp[2] = 1'b1;
        for (int j = 1; j <= W + 20; j++) begin
            flr_rcvd[2] = (j == 1) || (j == 20);
            tick();
            if (flr_comp[2] === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL absorb_pulses: got %0d want 1", pulses); end
        clear_inputs();
        wait_idle();
    endtask

    task automatic test_flush();
        sel_mmio_rsp[0]    = 1'b1;
        read_flush_done[0] = 1'b1;
        for (int j = 1; j <= W + 20; j++) begin
            logic exp;
            port_reset[0] = (j <= W + 10);
            tick();
            exp = (j >= W + 5) && (j <= W + 12);
            n_cmp++;
            if (flush_done[0] !== exp) begin
                n_bad++; $display("FAIL flush cyc %0d: got %b want %b", j, flush_done[0], exp);
            end
            n_cmp++;
            if (flush_done[NP-1:1] !== '0) begin
                n_bad++; $display("FAIL flush_others cyc %0d: got %b want 000", j, flush_done[NP-1:1]);
            end
        end
        clear_inputs();
        wait_idle();
    endtask

    task automatic test_drain_timeout();
        for (int j = 1; j <= W + 80; j++) begin
            logic [NP-1:0] exp_err;
            port_reset[3]   = (j == 1);
            sel_mmio_rsp[3] = (j > 60);
            tick();
            exp_err = (TO_EN && j == DT + 1) ? (NP'(1) << 3) : '0;
            n_cmp++;
            if (to_err !== exp_err) begin
                n_bad++; $display("FAIL drain_err cyc %0d: got %b want %b", j, to_err, exp_err);
            end
            if (j == 60) begin
                n_cmp++;
                if (port_n[3] !== !TO_EN) begin
                    n_bad++; $display("FAIL drain_port_n: got %b want %b", port_n[3], !TO_EN);
                end
                n_cmp++;
                if (afu[3] !== 1'b1 || busy[3] !== 1'b1) begin
                    n_bad++; $display("FAIL drain_afu_busy: got %b%b want 11", afu[3], busy[3]);
                end
            end
        end
        clear_inputs();
        wait_idle();
    endtask

    task automatic test_random();
        logic [NP-1:0] lvl = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 199) == 0) lvl[p] = ~lvl[p];
                flr_rcvd[p]        = ($urandom_range(0, 299) == 0);
                sel_mmio_rsp[p]    = ($urandom_range(0, 3) == 0);
                read_flush_done[p] = ($urandom_range(0, 1) == 1);
            end
            port_reset = lvl;
            tick();
            n_cmp++; if (afu !== e_afu) begin n_bad++; $display("FAIL rnd_afu cyc %0d: got %b want %b", i, afu, e_afu); end
            n_cmp++; if (port_n !== e_port_n) begin n_bad++; $display("FAIL rnd_port_n cyc %0d: got %b want %b", i, port_n, e_port_n); end
            n_cmp++; if (flr_comp !== e_comp) begin n_bad++; $display("FAIL rnd_comp cyc %0d: got %b want %b", i, flr_comp, e_comp); end
            n_cmp++; if (flr_pend !== m_pend) begin n_bad++; $display("FAIL rnd_pend cyc %0d: got %b want %b", i, flr_pend, m_pend); end
            n_cmp++; if (flush_done !== e_flush) begin n_bad++; $display("FAIL rnd_flush cyc %0d: got %b want %b", i, flush_done, e_flush); end
            n_cmp++; if (busy !== e_busy) begin n_bad++; $display("FAIL rnd_busy cyc %0d: got %b want %b", i, busy, e_busy); end
            n_cmp++; if (to_err !== e_err) begin n_bad++; $display("FAIL rnd_err cyc %0d: got %b want %b", i, to_err, e_err); end
        end
        clear_inputs();
        wait_idle();
    endtask

    task automatic test_async_reset();
        int pulses = 0;
        sel_mmio_rsp  = '1;
        flr_rcvd[0]   = 1'b1;
        port_reset[1] = 1'b1;
        tick();
        flr_rcvd[0] = 1'b0;
        repeat (40) tick();
        #2 rst_n_2x = 1'b0;
        #1;
        n_cmp++; if (afu !== '1) begin n_bad++; $display("FAIL arst_afu: got %b want 1111", afu); end
        n_cmp++; if (port_n !== '0) begin n_bad++; $display("FAIL arst_port_n: got %b want 0000", port_n); end
        n_cmp++; if (flr_pend !== '0) begin n_bad++; $display("FAIL arst_pend: got %b want 0000", flr_pend); end
        n_cmp++; if (busy !== '1) begin n_bad++; $display("FAIL arst_busy: got %b want 1111", busy); end
        n_cmp++; if (flr_comp !== '0 || to_err !== '0 || flush_done !== '0) begin
            n_bad++; $display("FAIL arst_pulses: got comp %b err %b flush %b want 0", flr_comp, to_err, flush_done);
        end
        model_reset();
        clear_inputs();
        @(negedge clk_2x);
        @(negedge clk_2x);
        rst_n_2x = 1'b1;
        for (int j = 1; j <= W + 10; j++) begin
            tick();
            if (flr_comp !== '0) pulses++;
            n_cmp++;
            if (afu !== e_afu) begin n_bad++; $display("FAIL arst_seq_afu cyc %0d: got %b want %b", j, afu, e_afu); end
        end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL arst_dropped_flr: got %0d pulses want 0", pulses); end
        n_cmp++; if (busy !== '0) begin n_bad++; $display("FAIL arst_idle: got busy %b want 0000", busy); end
    endtask

    initial begin
        test_reset();
        test_port_reset();
        test_flr();
        test_back_to_back();
        test_flush();
        test_drain_timeout();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
